// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/stall control slice.
// Provides the stall FSM state, the per-stage control bundle and the RUN-mode priority rules.
package pipeline_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } stall_state_t;

    // Bit order matches {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}.
    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE     = ctrl_t'(7'b000_0000);
    localparam ctrl_t CTRL_MEMWAIT  = ctrl_t'(7'b111_1001);
    localparam ctrl_t CTRL_BRANCH   = ctrl_t'(7'b000_0110);
    localparam ctrl_t CTRL_LOADUSE  = ctrl_t'(7'b110_0010);

    function automatic logic is_load_use(
        input logic                  mem_read_e,
        input logic [REG_ADDR_W-1:0] rd_e,
        input logic [REG_ADDR_W-1:0] rs1_d,
        input logic [REG_ADDR_W-1:0] rs2_d
    );
        return mem_read_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    endfunction

    // Priority memwait > taken branch > load-use.
    function automatic ctrl_t run_ctrl(
        input logic memwait,
        input logic pc_src_e,
        input logic loaduse
    );
        if (memwait)       return CTRL_MEMWAIT;
        else if (pc_src_e) return CTRL_BRANCH;
        else if (loaduse)  return CTRL_LOADUSE;
        else               return CTRL_NONE;
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard inputs and stall/flush outputs exchanged between the pipeline and its stall controller.
// The pipeline side is the master; the controller is the slave.
interface pipeline_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    import pipeline_pkg::*;

    logic [REG_ADDR_W-1:0] Rs1D_i;
    logic [REG_ADDR_W-1:0] Rs2D_i;
    logic [REG_ADDR_W-1:0] RdE_i;
    logic                  MemReadE_i;
    logic                  PCSrcE_i;
    logic                  MemReqM_i;
    logic                  MemAckM_i;

    logic                  StallF_o;
    logic                  StallD_o;
    logic                  StallE_o;
    logic                  StallM_o;
    logic                  FlushD_o;
    logic                  FlushE_o;
    logic                  FlushW_o;
    logic                  MemTimeout_o;
    logic [CNT_W-1:0]      StallCount_o;

    modport master (
        output Rs1D_i, Rs2D_i, RdE_i, MemReadE_i, PCSrcE_i, MemReqM_i, MemAckM_i,
        input  StallF_o, StallD_o, StallE_o, StallM_o,
        input  FlushD_o, FlushE_o, FlushW_o, MemTimeout_o, StallCount_o
    );

    modport slave (
        input  Rs1D_i, Rs2D_i, RdE_i, MemReadE_i, PCSrcE_i, MemReqM_i, MemAckM_i,
        output StallF_o, StallD_o, StallE_o, StallM_o,
        output FlushD_o, FlushE_o, FlushW_o, MemTimeout_o, StallCount_o
    );

endinterface

// File: rtl/stall_perf_counter.sv
// Free-running performance counter: counts enabled cycles, wrapping modulo 2^CNT_W.
module stall_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i) count_d = count_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, taken branch and data-memory wait,
// with a sticky memory-wait timeout and a stall-cycle performance counter.
module pipeline_stall_ctrl
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    pipeline_stall_ctrl_if.slave  bus
);

    localparam int              WAIT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic         memwait;
    logic         loaduse;
    stall_state_t state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic         timeout_q, timeout_d;
    ctrl_t        ctrl;

    assign memwait = bus.MemReqM_i & ~bus.MemAckM_i;
    assign loaduse = is_load_use(bus.MemReadE_i, bus.RdE_i, bus.Rs1D_i, bus.Rs2D_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= RUN;
        else       state_q <= state_d;
    end

    // Leaving MEM_WAIT happens on ack or when the request is withdrawn.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (memwait) state_d = MEM_WAIT;
            MEM_WAIT: if (bus.MemAckM_i || !bus.MemReqM_i) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // NOTE: ctrl gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        ctrl = CTRL_NONE;
        if (!rst_i) begin
            case (state_q)
                RUN:      ctrl = run_ctrl(memwait, bus.PCSrcE_i, loaduse);
                MEM_WAIT: ctrl = memwait ? CTRL_MEMWAIT
                                         : run_ctrl(1'b0, bus.PCSrcE_i, loaduse);
                default:  ctrl = CTRL_NONE;
            endcase
        end
    end

    // Counts consecutive stalled memory cycles, saturating at the timeout threshold.
    always_comb begin
        wait_cnt_d = '0;
        timeout_d  = timeout_q;
        if (memwait) begin
            wait_cnt_d = (wait_cnt_q == WAIT_LAST) ? wait_cnt_q : wait_cnt_q + 1'b1;
            if (wait_cnt_q == WAIT_LAST) timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    stall_perf_counter #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (ctrl.stall_f),
        .count_o (bus.StallCount_o)
    );

    assign bus.StallF_o     = ctrl.stall_f;
    assign bus.StallD_o     = ctrl.stall_d;
    assign bus.StallE_o     = ctrl.stall_e;
    assign bus.StallM_o     = ctrl.stall_m;
    assign bus.FlushD_o     = ctrl.flush_d;
    assign bus.FlushE_o     = ctrl.flush_e;
    assign bus.FlushW_o     = ctrl.flush_w;
    assign bus.MemTimeout_o = timeout_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: a table of single-cycle hazard vectors plus
// hand-written memory-wait, timeout, counter-wrap and async-reset sequences.
module tb_pipeline_stall_ctrl;
    import pipeline_pkg::*;

    localparam int TB_CNT_W   = 4;
    localparam int TB_TIMEOUT = 4;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rde;
        logic       memrd;
        logic       pcsrc;
        logic       req;
        logic       ack;
        logic [6:0] exp;
    } vec_t;

    localparam logic [6:0] O_NONE = 7'b000_0000;
    localparam logic [6:0] O_MEMW = 7'b111_1001;
    localparam logic [6:0] O_BR   = 7'b000_0110;
    localparam logic [6:0] O_LU   = 7'b110_0010;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [TB_CNT_W-1:0] exp_cnt;
    vec_t vecs [10];

    pipeline_stall_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();

    pipeline_stall_ctrl #(
        .TIMEOUT_CYCLES (TB_TIMEOUT),
        .CNT_W          (TB_CNT_W)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] outs();
        return {bus.StallF_o, bus.StallD_o, bus.StallE_o, bus.StallM_o,
                bus.FlushD_o, bus.FlushE_o, bus.FlushW_o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rde,
                         input logic memrd, input logic pcsrc, input logic req, input logic ack);
        bus.Rs1D_i     = rs1;
        bus.Rs2D_i     = rs2;
        bus.RdE_i      = rde;
        bus.MemReadE_i = memrd;
        bus.PCSrcE_i   = pcsrc;
        bus.MemReqM_i  = req;
        bus.MemAckM_i  = ack;
    endtask

    // Advance one clock and return at the following falling edge; stall_f is the model's StallF.
    task automatic tick(input logic stall_f);
        @(posedge clk);
        if (stall_f) exp_cnt = exp_cnt + 1'b1;
        @(negedge clk);
    endtask

    // Apply inputs at a falling edge, check comb outputs and counter, then clock.
    task automatic step(input string name, input logic [6:0] exp_o);
        #1;
        check({name, "_outs"}, 32'(outs()), 32'(exp_o));
        check({name, "_cnt"}, 32'(bus.StallCount_o), 32'(exp_cnt));
        tick(exp_o[6]);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = '0;

        vecs[0] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
        vecs[1] = '{5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[2] = '{5'd2, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
        vecs[3] = '{5'd9, 5'd4, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[4] = '{5'd0, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE};
        vecs[5] = '{5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
        vecs[6] = '{5'd8, 5'd2, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, O_BR};
        vecs[7] = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, O_BR};
        vecs[8] = '{5'd4, 5'd3, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, O_LU};
        vecs[9] = '{5'd3, 5'd4, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, O_NONE};

        // Reset held with hazardous inputs: every stall/flush must stay low.
        rst = 1'b1;
        drive(5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        #3;
        check("reset_outs", 32'(outs()), 32'(O_NONE));
        check("reset_cnt", 32'(bus.StallCount_o), 32'd0);
        check("reset_timeout", 32'(bus.MemTimeout_o), 32'd0);
        @(negedge clk);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_state", 32'(dut.state_q), 32'(RUN));

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rde, vecs[i].memrd,
                  vecs[i].pcsrc, vecs[i].req, vecs[i].ack);
            step($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Memory wait for 3 cycles with a branch and load-use pending: branch is held.
        for (int i = 0; i < 3; i++) begin
            drive(5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
            #1;
            check($sformatf("mw_state%0d", i), 32'(dut.state_q), 32'(i == 0 ? RUN : MEM_WAIT));
            step($sformatf("mw%0d", i), O_MEMW);
        end
        check("mw_no_timeout", 32'(bus.MemTimeout_o), 32'd0);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("mw_ack", O_NONE);
        check("mw_back_run", 32'(dut.state_q), 32'(RUN));
        check("mw_cnt_plus3", 32'(bus.StallCount_o), 32'(exp_cnt));

        // Request withdrawn without ack also leaves MEM_WAIT and clears the wait count.
        for (int i = 0; i < 2; i++) begin
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            step($sformatf("drop_wait%0d", i), O_MEMW);
        end
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("drop_release", O_NONE);
        check("drop_back_run", 32'(dut.state_q), 32'(RUN));

        // Timeout: set only after the 4th consecutive wait cycle, then sticky.
        for (int i = 0; i < 6; i++) begin
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            step($sformatf("to_wait%0d", i), O_MEMW);
            check($sformatf("to_flag%0d", i), 32'(bus.MemTimeout_o), 32'(i >= 3));
        end
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("to_ack", O_NONE);
        for (int i = 0; i < 3; i++) begin
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            step($sformatf("to_idle%0d", i), O_NONE);
            check($sformatf("to_sticky%0d", i), 32'(bus.MemTimeout_o), 32'd1);
        end

        // Repeated load-use drives the 4-bit counter through its wrap.
        for (int i = 0; i < 17; i++) begin
            drive(5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
            step($sformatf("wrap%0d", i), O_LU);
        end
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("wrap_done", O_NONE);

        // Async reset in the middle of a memory wait.
        for (int i = 0; i < 2; i++) begin
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            step($sformatf("ar_wait%0d", i), O_MEMW);
        end
        check("ar_in_wait", 32'(dut.state_q), 32'(MEM_WAIT));
        #2;
        rst = 1'b1;
        #1;
        exp_cnt = '0;
        check("ar_outs", 32'(outs()), 32'(O_NONE));
        check("ar_cnt", 32'(bus.StallCount_o), 32'd0);
        check("ar_timeout", 32'(bus.MemTimeout_o), 32'd0);
        check("ar_state", 32'(dut.state_q), 32'(RUN));
        @(negedge clk);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step("ar_release", O_NONE);
        drive(5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        step("ar_post_lu", O_LU);
        check("ar_post_cnt", 32'(bus.StallCount_o), 32'(exp_cnt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
